// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage.
//   XLEN / DIV_STEPS : datapath width and divider quotient bits (kept equal)
//   ALU_*            : ALU function codes, including the divide group 0x0E-0x11
//   ALU_OPA_* / OPB_*: operand mux selects
//   BR_*             : conditional-branch funct3 encodings
//   div_state_t      : divider FSM states
package ex_pkg;
  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [4:0] ALU_ADD    = 5'h00;
  localparam logic [4:0] ALU_SUB    = 5'h01;
  localparam logic [4:0] ALU_SLT    = 5'h02;
  localparam logic [4:0] ALU_SLTU   = 5'h03;
  localparam logic [4:0] ALU_AND    = 5'h04;
  localparam logic [4:0] ALU_OR     = 5'h05;
  localparam logic [4:0] ALU_XOR    = 5'h06;
  localparam logic [4:0] ALU_SLL    = 5'h07;
  localparam logic [4:0] ALU_SRL    = 5'h08;
  localparam logic [4:0] ALU_SRA    = 5'h09;
  localparam logic [4:0] ALU_MUL    = 5'h0A;
  localparam logic [4:0] ALU_MULH   = 5'h0B;
  localparam logic [4:0] ALU_MULHSU = 5'h0C;
  localparam logic [4:0] ALU_MULHU  = 5'h0D;
  localparam logic [4:0] ALU_DIV    = 5'h0E;
  localparam logic [4:0] ALU_DIVU   = 5'h0F;
  localparam logic [4:0] ALU_REM    = 5'h10;
  localparam logic [4:0] ALU_REMU   = 5'h11;

  localparam logic [1:0] ALU_OPA_IS_REGA = 2'd0;
  localparam logic [1:0] ALU_OPA_IS_PC   = 2'd1;
  localparam logic [1:0] ALU_OPA_IS_ZR   = 2'd2;

  localparam logic [1:0] ALU_OPB_IS_REGB = 2'd0;
  localparam logic [1:0] ALU_OPB_IS_IMM  = 2'd1;
  localparam logic [1:0] ALU_OPB_IS_4    = 2'd2;

  localparam logic [2:0] BR_BEQ  = 3'd0;
  localparam logic [2:0] BR_BNE  = 3'd1;
  localparam logic [2:0] BR_BLT  = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BLTU = 3'd6;
  localparam logic [2:0] BR_BGEU = 3'd7;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  function automatic logic is_div_func(input logic [4:0] func);
    return (func == ALU_DIV) || (func == ALU_DIVU) ||
           (func == ALU_REM) || (func == ALU_REMU);
  endfunction
endpackage

// File: rtl/ex_divider.sv
// Iterative restoring divider (one quotient bit per cycle) with start/busy/done.
//   clk, rst         : clock, async active-low reset (aborts any divide)
//   start            : request a divide this cycle (accepted only in IDLE)
//   is_signed, is_rem: DIV/REM vs DIVU/REMU, quotient vs remainder
//   dividend, divisor: operands, sampled on the issue cycle only
//   busy             : FSM not IDLE
//   stall            : issue cycle plus every CALC cycle
//   done             : DONE state; result is valid
//   result           : signed-fixed quotient or remainder
// Build option EX_DIV_ZERO_FAST_EN: divide-by-zero and signed overflow skip
// CALC and go straight to DONE.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, count 0..DIV_STEPS-1
// DONE  | result presented for one cycle
module ex_divider
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state, state_next;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  quo, rem, dvsr;
  logic             neg_q, neg_r, div_zero, ovf, op_rem;
  logic [XLEN-1:0]  abs_a, abs_b, q_fix, r_fix;
  logic [XLEN:0]    rem_shift, rem_diff;
  logic             rem_ge, start_ok, start_zero, start_ovf, fast;

  // Gating with rst keeps stall low while reset is held, even if a divide
  // is still presented upstream.
  assign start_ok   = start && rst;
  assign abs_a      = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
  assign abs_b      = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
  assign start_zero = (divisor == '0);
  assign start_ovf  = is_signed && (dividend == INT_MIN) && (divisor == '1);

`ifdef EX_DIV_ZERO_FAST_EN
  assign fast = start_zero || start_ovf;
`else
  assign fast = 1'b0;
`endif

  assign rem_shift = {rem, quo[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvsr};
  assign rem_ge    = (rem_shift >= {1'b0, dvsr});
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start_ok) begin
        stall      = 1'b1;
        state_next = fast ? DONE : CALC;
      end
      CALC: begin
        stall = 1'b1;
        if (count == CNT_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      op_rem   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && start_ok) begin
        quo      <= abs_a;
        // A fast-path divide by zero never runs the steps, so |dividend| is
        // preloaded to let the sign fix-up reproduce the dividend.
        rem      <= fast ? abs_a : '0;
        dvsr     <= abs_b;
        count    <= '0;
        neg_q    <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        neg_r    <= is_signed && dividend[XLEN-1];
        div_zero <= start_zero;
        ovf      <= start_ovf;
        op_rem   <= is_rem;
      end else if (state == CALC) begin
        count <= count + CNT_W'(1);
        quo   <= {quo[XLEN-2:0], rem_ge};
        rem   <= rem_ge ? rem_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
      end
    end
  end

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  // Divide-by-zero remainder needs no special case: r_fix already equals the
  // dividend (the steps leave |dividend| in rem, or it was preloaded).
  always_comb begin
    result = op_rem ? r_fix : q_fix;
    if (div_zero)  result = op_rem ? r_fix : '1;
    else if (ovf)  result = op_rem ? '0 : INT_MIN;
  end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand muxes, single-cycle ALU (incl. multiply), branch and
// jump resolution, and an iterative divider that stalls upstream.
//   clk, rst              : clock, async active-low reset
//   id_ex_*               : ID/EX register contents for the EX instruction
//   ex_alu_result_out     : ALU/divide result, link address for jumps
//   ex_take_branch_out    : redirect fetch this cycle
//   ex_target_pc_out      : redirect target
//   ex_stall_out          : hold IF/ID/ID-EX, bubble into EX/MEM
//   ex_valid_inst_out     : result valid for EX/MEM capture
// Build option EX_DIV_ZERO_FAST_EN (see ex_divider): single-cycle-stall
// handling of divide-by-zero and signed overflow.
module ex_stage
  import ex_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            id_ex_valid_inst,
  input  logic [XLEN-1:0] id_ex_pc,
  input  logic [XLEN-1:0] id_ex_pc_add_opa,
  input  logic [XLEN-1:0] id_ex_ra_value,
  input  logic [XLEN-1:0] id_ex_rb_value,
  input  logic [XLEN-1:0] id_ex_immediate,
  input  logic [1:0]      id_ex_opa_select,
  input  logic [1:0]      id_ex_opb_select,
  input  logic [4:0]      id_ex_alu_func,
  input  logic [2:0]      id_ex_funct3,
  input  logic            id_ex_cond_branch,
  input  logic            id_ex_uncond_branch,
  output logic [XLEN-1:0] ex_alu_result_out,
  output logic            ex_take_branch_out,
  output logic [XLEN-1:0] ex_target_pc_out,
  output logic            ex_stall_out,
  output logic            ex_valid_inst_out
);
  logic [XLEN-1:0]   opa, opb, alu_result, div_result, jump_sum;
  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic              a_signed, b_signed, br_taken;
  logic              is_div, div_start, div_busy, div_stall, div_done;

  always_comb begin
    case (id_ex_opa_select)
      ALU_OPA_IS_REGA: opa = id_ex_ra_value;
      ALU_OPA_IS_PC:   opa = id_ex_pc;
      default:         opa = '0;
    endcase
    case (id_ex_opb_select)
      ALU_OPB_IS_REGB: opb = id_ex_rb_value;
      ALU_OPB_IS_IMM:  opb = id_ex_immediate;
      ALU_OPB_IS_4:    opb = XLEN'(4);
      default:         opb = '0;
    endcase
  end

  // One 64-bit multiplier; the operand extension picks the signedness.
  assign a_signed = (id_ex_alu_func == ALU_MUL) || (id_ex_alu_func == ALU_MULH) ||
                    (id_ex_alu_func == ALU_MULHSU);
  assign b_signed = (id_ex_alu_func == ALU_MUL) || (id_ex_alu_func == ALU_MULH);
  assign mul_a    = {{XLEN{a_signed & opa[XLEN-1]}}, opa};
  assign mul_b    = {{XLEN{b_signed & opb[XLEN-1]}}, opb};
  assign product  = mul_a * mul_b;

  always_comb begin
    alu_result = '0;
    case (id_ex_alu_func)
      ALU_ADD:    alu_result = opa + opb;
      ALU_SUB:    alu_result = opa - opb;
      ALU_SLT:    alu_result = {{(XLEN-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU:   alu_result = {{(XLEN-1){1'b0}}, opa < opb};
      ALU_AND:    alu_result = opa & opb;
      ALU_OR:     alu_result = opa | opb;
      ALU_XOR:    alu_result = opa ^ opb;
      ALU_SLL:    alu_result = opa << opb[4:0];
      ALU_SRL:    alu_result = opa >> opb[4:0];
      ALU_SRA:    alu_result = $signed(opa) >>> opb[4:0];
      ALU_MUL:    alu_result = product[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_result = product[2*XLEN-1:XLEN];
      default:    alu_result = '0;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (id_ex_funct3)
      BR_BEQ:  br_taken = (id_ex_ra_value == id_ex_rb_value);
      BR_BNE:  br_taken = (id_ex_ra_value != id_ex_rb_value);
      BR_BLT:  br_taken = ($signed(id_ex_ra_value) <  $signed(id_ex_rb_value));
      BR_BGE:  br_taken = ($signed(id_ex_ra_value) >= $signed(id_ex_rb_value));
      BR_BLTU: br_taken = (id_ex_ra_value <  id_ex_rb_value);
      BR_BGEU: br_taken = (id_ex_ra_value >= id_ex_rb_value);
      default: br_taken = 1'b0;
    endcase
  end

  assign jump_sum = id_ex_pc_add_opa + id_ex_immediate;

  assign is_div    = is_div_func(id_ex_alu_func);
  assign div_start = id_ex_valid_inst && is_div && !div_busy;

  ex_divider u_divider (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .is_signed ((id_ex_alu_func == ALU_DIV) || (id_ex_alu_func == ALU_REM)),
    .is_rem    ((id_ex_alu_func == ALU_REM) || (id_ex_alu_func == ALU_REMU)),
    .dividend  (opa),
    .divisor   (opb),
    .busy      (div_busy),
    .stall     (div_stall),
    .done      (div_done),
    .result    (div_result)
  );

  assign ex_alu_result_out  = is_div ? div_result : alu_result;
  assign ex_take_branch_out = id_ex_valid_inst &&
                              (id_ex_uncond_branch || (id_ex_cond_branch && br_taken));
  assign ex_target_pc_out   = id_ex_uncond_branch ? {jump_sum[XLEN-1:1], 1'b0} : alu_result;
  assign ex_stall_out       = div_stall;
  assign ex_valid_inst_out  = !div_stall && (id_ex_valid_inst || div_done);
endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_DIV_ZERO_FAST_EN
  localparam int SPECIAL_STALL = 1;
`else
  localparam int SPECIAL_STALL = 33;
`endif
  localparam int NORMAL_STALL = 33;

  logic        clk, rst;
  logic        valid, cond, uncond;
  logic [31:0] pc, pc_add_opa, ra, rb, imm;
  logic [1:0]  opa_sel, opb_sel;
  logic [4:0]  func;
  logic [2:0]  funct3;
  logic [31:0] result, target;
  logic        take, stall, valid_out;

  int total = 0;
  int passed = 0;

  ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .id_ex_valid_inst    (valid),
    .id_ex_pc            (pc),
    .id_ex_pc_add_opa    (pc_add_opa),
    .id_ex_ra_value      (ra),
    .id_ex_rb_value      (rb),
    .id_ex_immediate     (imm),
    .id_ex_opa_select    (opa_sel),
    .id_ex_opb_select    (opb_sel),
    .id_ex_alu_func      (func),
    .id_ex_funct3        (funct3),
    .id_ex_cond_branch   (cond),
    .id_ex_uncond_branch (uncond),
    .ex_alu_result_out   (result),
    .ex_take_branch_out  (take),
    .ex_target_pc_out    (target),
    .ex_stall_out        (stall),
    .ex_valid_inst_out   (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  oa, ob;
    logic [4:0]  f;
    logic [2:0]  f3;
    logic        c, u;
    logic [31:0] pc, pao, ra, rb, imm;
    logic [31:0] er;
    logic        et, ct;
    logic [31:0] etg;
    logic        ev;
  } vec_t;

  vec_t vecs [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive_alu(input logic v, input logic [1:0] oa, input logic [1:0] ob,
                           input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    valid = v; opa_sel = oa; opb_sel = ob; func = f;
    ra = a; rb = b; imm = 32'h0; pc = 32'h0; pc_add_opa = 32'h0;
    funct3 = 3'd0; cond = 1'b0; uncond = 1'b0;
  endtask

  task automatic run_div(input string name, input logic [4:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int  n;
    logic bubble_ok;
    @(posedge clk); #1;
    drive_alu(1'b1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, f, a, b);
    n = 0;
    bubble_ok = 1'b1;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      if (valid_out) bubble_ok = 1'b0;
      @(negedge clk);
    end
    check({name, " stall_cycles"}, 32'(n), 32'(exp_stall));
    check({name, " result"}, result, exp);
    check({name, " valid_done"}, 32'(valid_out), 32'd1);
    check({name, " bubble"}, 32'(bubble_ok), 32'd1);
  endtask

  initial begin
    //          v  opa              opb              func        f3 c  u  pc          pao         ra            rb            imm           exp_res       et ct exp_tgt       ev
    vecs[0]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_IMM,  ALU_ADD,    0, 0, 0, 32'h0,      32'h0,      32'd7,        32'd0,        32'hFFFFFFFD, 32'd4,        0, 0, 32'h0,        1};
    vecs[1]  = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_IMM,  ALU_ADD,    4, 1, 0, 32'h100,    32'h0,      32'hFFFFFFFF, 32'd1,        32'h20,       32'h120,      1, 1, 32'h120,      1};
    vecs[2]  = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_IMM,  ALU_ADD,    6, 1, 0, 32'h100,    32'h0,      32'hFFFFFFFF, 32'd1,        32'h20,       32'h120,      0, 0, 32'h0,        1};
    vecs[3]  = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_4,    ALU_ADD,    0, 0, 1, 32'h40,     32'h203,    32'h0,        32'h0,        32'h4,        32'h44,       1, 1, 32'h206,      1};
    vecs[4]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_SUB,    0, 0, 0, 32'h0,      32'h0,      32'd10,       32'd3,        32'h0,        32'd7,        0, 0, 32'h0,        1};
    vecs[5]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_SLT,    0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd1,        32'h0,        32'd1,        0, 0, 32'h0,        1};
    vecs[6]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_SLTU,   0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd1,        32'h0,        32'd0,        0, 0, 32'h0,        1};
    vecs[7]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_IMM,  ALU_SRA,    0, 0, 0, 32'h0,      32'h0,      32'h80000000, 32'd0,        32'd4,        32'hF8000000, 0, 0, 32'h0,        1};
    vecs[8]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_IMM,  ALU_SRL,    0, 0, 0, 32'h0,      32'h0,      32'h80000000, 32'd0,        32'd4,        32'h08000000, 0, 0, 32'h0,        1};
    vecs[9]  = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_IMM,  ALU_SLL,    0, 0, 0, 32'h0,      32'h0,      32'd1,        32'd0,        32'h23,       32'd8,        0, 0, 32'h0,        1};
    vecs[10] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_MUL,    0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFE, 0, 0, 32'h0,        1};
    vecs[11] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_MULH,   0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFF, 0, 0, 32'h0,        1};
    vecs[12] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_MULHU,  0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd2,        32'h0,        32'd1,        0, 0, 32'h0,        1};
    vecs[13] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_MULHSU, 0, 0, 0, 32'h0,      32'h0,      32'hFFFFFFFF, 32'd2,        32'h0,        32'hFFFFFFFF, 0, 0, 32'h0,        1};
    vecs[14] = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_IMM,  ALU_ADD,    0, 1, 0, 32'h200,    32'h0,      32'd5,        32'd5,        32'hFFFFFFF0, 32'h1F0,      1, 1, 32'h1F0,      1};
    vecs[15] = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_IMM,  ALU_ADD,    5, 1, 0, 32'h200,    32'h0,      32'hFFFFFFFF, 32'd1,        32'd8,        32'h208,      0, 0, 32'h0,        1};
    vecs[16] = '{1, ALU_OPA_IS_PC,   ALU_OPB_IS_IMM,  ALU_ADD,    7, 1, 0, 32'h200,    32'h0,      32'hFFFFFFFF, 32'd1,        32'd8,        32'h208,      1, 1, 32'h208,      1};
    vecs[17] = '{0, ALU_OPA_IS_PC,   ALU_OPB_IS_4,    ALU_ADD,    0, 0, 1, 32'h40,     32'h203,    32'h0,        32'h0,        32'h4,        32'h44,       0, 0, 32'h0,        0};
    vecs[18] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_XOR,    0, 0, 0, 32'h0,      32'h0,      32'h0000F0F0, 32'h000000FF, 32'h0,        32'h0000F00F, 0, 0, 32'h0,        1};
    vecs[19] = '{1, ALU_OPA_IS_ZR,   ALU_OPB_IS_IMM,  ALU_ADD,    0, 0, 0, 32'h0,      32'h0,      32'd99,       32'd0,        32'd5,        32'd5,        0, 0, 32'h0,        1};
    vecs[20] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_OR,     0, 0, 0, 32'h0,      32'h0,      32'h000000F0, 32'h0000000F, 32'h0,        32'h000000FF, 0, 0, 32'h0,        1};
    vecs[21] = '{1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_AND,    0, 0, 0, 32'h0,      32'h0,      32'h000000F0, 32'h0000003C, 32'h0,        32'h00000030, 0, 0, 32'h0,        1};

    // Reset state, with a valid divide presented while reset is held.
    rst = 1'b1;
    drive_alu(1'b1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_DIV, 32'd9, 32'd3);
    #2 rst = 1'b0;
    #10;
    check("reset stall", 32'(stall), 32'd0);
    check("reset take", 32'(take), 32'd0);
    check("reset valid_out", 32'(valid_out), 32'd1);
    @(negedge clk);
    drive_alu(1'b0, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_ADD, 32'd0, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      valid = vecs[i].v; opa_sel = vecs[i].oa; opb_sel = vecs[i].ob; func = vecs[i].f;
      funct3 = vecs[i].f3; cond = vecs[i].c; uncond = vecs[i].u; pc = vecs[i].pc;
      pc_add_opa = vecs[i].pao; ra = vecs[i].ra; rb = vecs[i].rb; imm = vecs[i].imm;
      @(negedge clk);
      check($sformatf("vec%0d result", i), result, vecs[i].er);
      check($sformatf("vec%0d take", i), 32'(take), 32'(vecs[i].et));
      if (vecs[i].ct) check($sformatf("vec%0d target", i), target, vecs[i].etg);
      check($sformatf("vec%0d stall", i), 32'(stall), 32'd0);
      check($sformatf("vec%0d valid", i), 32'(valid_out), 32'(vecs[i].ev));
    end

    // Back-to-back divides: each call issues right after the previous DONE.
    run_div("div -7/2",     ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, NORMAL_STALL);
    run_div("rem -7/2",     ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, NORMAL_STALL);
    run_div("div 100/7",    ALU_DIV,  32'd100,      32'd7,        32'd14,       NORMAL_STALL);
    run_div("div 7/-2",     ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, NORMAL_STALL);
    run_div("rem 7/-2",     ALU_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        NORMAL_STALL);
    run_div("divu big",     ALU_DIVU, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, NORMAL_STALL);
    run_div("remu 20/6",    ALU_REMU, 32'd20,       32'd6,        32'd2,        NORMAL_STALL);
    run_div("divu min/-1",  ALU_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        NORMAL_STALL);
    run_div("divu x/0",     ALU_DIVU, 32'h1234,     32'd0,        32'hFFFFFFFF, SPECIAL_STALL);
    run_div("remu x/0",     ALU_REMU, 32'h1234,     32'd0,        32'h1234,     SPECIAL_STALL);
    run_div("rem -5/0",     ALU_REM,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SPECIAL_STALL);
    run_div("div -5/0",     ALU_DIV,  32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, SPECIAL_STALL);
    run_div("div ovf",      ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_STALL);
    run_div("rem ovf",      ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        SPECIAL_STALL);

    // Reset in the middle of CALC (count == 10 after the 11th edge).
    @(posedge clk); #1;
    drive_alu(1'b1, ALU_OPA_IS_REGA, ALU_OPB_IS_REGB, ALU_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (11) @(posedge clk);
    #2;
    check("midreset stall_before", 32'(stall), 32'd1);
    rst = 1'b0;
    #1;
    check("midreset stall_async", 32'(stall), 32'd0);
    check("midreset take", 32'(take), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    begin
      logic spurious;
      spurious = 1'b0;
      repeat (3) begin
        @(negedge clk);
        if (valid_out || stall) spurious = 1'b1;
      end
      check("midreset after_release", 32'(spurious), 32'd0);
    end
    run_div("div after reset", ALU_DIV, 32'd100, 32'd7, 32'd14, NORMAL_STALL);

    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
